// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the BCD/refresh logic and the 7-segment scan driver.
// The master drives the refresh tick and display data; the slave drives the board pins.
interface seg_scan_driver_if;
   logic        Refresh;
   logic        Load;
   logic [15:0] BcdIn;
   logic [3:0]  DpIn;
   logic        BlankLz;
   logic [3:0]  An;
   logic [6:0]  Seg;
   logic        Dp;
   logic        FrameDone;

   modport master (
      output Refresh, Load, BcdIn, DpIn, BlankLz,
      input  An, Seg, Dp, FrameDone
   );

   modport slave (
      input  Refresh, Load, BcdIn, DpIn, BlankLz,
      output An, Seg, Dp, FrameDone
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with double-buffered data, anti-ghost
// blanking between digits, leading-zero suppression and registered pin outputs.
module seg_scan_driver #(
   parameter int BLANK_CYCLES = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   seg_scan_driver_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

   localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

   state_t      state, next_state;
   logic [1:0]  index, next_index;
   logic [3:0]  blank_cnt, next_blank_cnt;
   logic        refresh_q;
   logic        step;
   logic        frame_start;
   logic        wrap;

   logic [15:0] active_bcd, shadow_bcd;
   logic [3:0]  active_dp, shadow_dp;
   logic        pending;

   logic [3:0]  an_d;
   logic [6:0]  seg_d;
   logic        dp_d;
   logic [3:0]  nibble;
   logic [3:0]  lz_blank;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         default: decode = 7'b0000110;
      endcase
   endfunction

   assign step  = (bus.Refresh != refresh_q);
   assign wrap  = step && (state != IDLE) && (index == 2'd3);
   // Leaving IDLE also begins a frame, so a Load issued before the first step is shown at once.
   assign frame_start = wrap || (step && (state == IDLE));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         index     <= 2'd0;
         blank_cnt <= 4'd0;
         refresh_q <= 1'b0;
      end else begin
         state     <= next_state;
         index     <= next_index;
         blank_cnt <= next_blank_cnt;
         refresh_q <= bus.Refresh;
      end
   end

   always_comb begin
      next_state     = state;
      next_index     = index;
      next_blank_cnt = blank_cnt;
      case (state)
         IDLE: begin
            if (step) begin
               next_state     = BLANK;
               next_blank_cnt = BLANK_LOAD;
            end
         end
         BLANK: begin
            if (step) begin
               next_index     = index + 2'd1;
               next_blank_cnt = BLANK_LOAD;
            end else if (blank_cnt == 4'd0) begin
               next_state = DRIVE;
            end else begin
               next_blank_cnt = blank_cnt - 4'd1;
            end
         end
         DRIVE: begin
            if (step) begin
               next_state     = BLANK;
               next_index     = index + 2'd1;
               next_blank_cnt = BLANK_LOAD;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // A Load landing on the frame boundary bypasses the shadow so it is not delayed a whole frame.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         active_bcd <= 16'h0000;
         active_dp  <= 4'h0;
         shadow_bcd <= 16'h0000;
         shadow_dp  <= 4'h0;
         pending    <= 1'b0;
      end else if (bus.Load && frame_start) begin
         active_bcd <= bus.BcdIn;
         active_dp  <= bus.DpIn;
         shadow_bcd <= bus.BcdIn;
         shadow_dp  <= bus.DpIn;
         pending    <= 1'b0;
      end else if (bus.Load) begin
         shadow_bcd <= bus.BcdIn;
         shadow_dp  <= bus.DpIn;
         pending    <= 1'b1;
      end else if (frame_start && pending) begin
         active_bcd <= shadow_bcd;
         active_dp  <= shadow_dp;
         pending    <= 1'b0;
      end
   end

   assign lz_blank[3] = bus.BlankLz && (active_bcd[15:12] == 4'h0);
   assign lz_blank[2] = lz_blank[3] && (active_bcd[11:8] == 4'h0);
   assign lz_blank[1] = lz_blank[2] && (active_bcd[7:4] == 4'h0);
   assign lz_blank[0] = 1'b0;
   assign nibble      = active_bcd[{next_index, 2'b00} +: 4];

   // Outputs are computed from the next state so the pins change on the same edge as the FSM.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
      if (next_state == DRIVE) begin
         an_d  = ~(4'b0001 << next_index);
         seg_d = lz_blank[next_index] ? 7'b1111111 : decode(nibble);
         dp_d  = ~active_dp[next_index];
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         bus.An        <= 4'b1111;
         bus.Seg       <= 7'b1111111;
         bus.Dp        <= 1'b1;
         bus.FrameDone <= 1'b0;
      end else begin
         bus.An        <= an_d;
         bus.Seg       <= seg_d;
         bus.Dp        <= dp_d;
         bus.FrameDone <= wrap;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues the expected digit image,
// a negedge monitor pops and compares each time a new digit lights up.
module tb_seg_scan_driver;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic Clk;
   logic Rst;
   int   vectors;
   int   miscompares;
   int   fd_count;
   logic [3:0] prev_an;
   exp_t exp_q[$];

   seg_scan_driver_if bus ();
   seg_scan_driver_if bus3 ();

   seg_scan_driver #(.BLANK_CYCLES(1)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus.slave)
   );

   seg_scan_driver #(.BLANK_CYCLES(3)) dut3 (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus3.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One scan step on the main DUT; optionally strobe Load on the very cycle the step is seen.
   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                                input bit withLoad, input logic [15:0] bcd, input logic [3:0] dpv);
      exp_t e;
      e.an  = an;
      e.seg = seg;
      e.dp  = dp;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
      bus.Refresh = ~bus.Refresh;
      if (withLoad) begin
         bus.Load  = 1'b1;
         bus.BcdIn = bcd;
         bus.DpIn  = dpv;
      end
      @(posedge Clk);
      #1;
      bus.Load = 1'b0;
      repeat (7) @(posedge Clk);
   endtask

   task automatic loadData(input logic [15:0] bcd, input logic [3:0] dpv);
      @(posedge Clk);
      #1;
      bus.Load  = 1'b1;
      bus.BcdIn = bcd;
      bus.DpIn  = dpv;
      @(posedge Clk);
      #1;
      bus.Load = 1'b0;
   endtask

   always @(negedge Clk) begin
      if (!Rst) begin
         if (bus.FrameDone) fd_count++;
         if (bus.An != 4'hF && prev_an == 4'hF) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_digit: got %h/%h/%b, expected none", bus.An, bus.Seg, bus.Dp);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("digit_image", {20'd0, bus.An, bus.Seg, bus.Dp}, {20'd0, e.an, e.seg, e.dp});
            end
         end
      end
      prev_an <= bus.An;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int guard;
      vectors     = 0;
      miscompares = 0;
      fd_count    = 0;
      prev_an     = 4'hF;
      Rst         = 1'b1;
      bus.Refresh  = 1'b0; bus.Load  = 1'b0; bus.BcdIn  = 16'h0; bus.DpIn  = 4'h0; bus.BlankLz  = 1'b0;
      bus3.Refresh = 1'b0; bus3.Load = 1'b0; bus3.BcdIn = 16'h0; bus3.DpIn = 4'h0; bus3.BlankLz = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("reset_an", {28'd0, bus.An}, 32'hF);
      checkOutput("reset_seg", {25'd0, bus.Seg}, 32'h7F);
      checkOutput("reset_dp", {31'd0, bus.Dp}, 32'h1);
      checkOutput("reset_framedone", {31'd0, bus.FrameDone}, 32'h0);
      Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkOutput("idle_an", {28'd0, bus.An}, 32'hF);

      // Blank length with BLANK_CYCLES=3, measured on the step into digit 1
      @(posedge Clk); #1; bus3.Refresh = ~bus3.Refresh;
      repeat (10) @(posedge Clk);
      #1;
      checkOutput("b3_first_digit", {28'd0, bus3.An}, 32'hE);
      @(posedge Clk); #1; bus3.Refresh = ~bus3.Refresh;
      guard = 0;
      do begin
         @(negedge Clk);
         guard++;
      end while (bus3.An != 4'hF && guard < 20);
      n = 0;
      while (bus3.An == 4'hF && n < 20) begin
         n++;
         @(negedge Clk);
      end
      checkOutput("b3_blank_len", n, 3);
      checkOutput("b3_next_digit", {28'd0, bus3.An}, 32'hD);

      // Basic scan of 1234 with a lit DP on digit 1
      loadData(16'h1234, 4'b0010);
      applyStimulus(4'hE, 7'h19, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hD, 7'h30, 1'b0, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h24, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h79, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_first_frame", fd_count, 0);

      // Mid-frame load is held until the wrap
      applyStimulus(4'hE, 7'h19, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_wrap1", fd_count, 1);
      applyStimulus(4'hD, 7'h30, 1'b0, 0, 16'h0, 4'h0);
      loadData(16'h5678, 4'b0000);
      applyStimulus(4'hB, 7'h24, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h79, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_before_wrap2", fd_count, 1);
      applyStimulus(4'hE, 7'h00, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_wrap2", fd_count, 2);
      applyStimulus(4'hD, 7'h78, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h02, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h12, 1'b1, 0, 16'h0, 4'h0);

      // Leading-zero blanking on and off
      loadData(16'h0007, 4'b0000);
      bus.BlankLz = 1'b1;
      applyStimulus(4'hE, 7'h78, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hD, 7'h7F, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h7F, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h7F, 1'b1, 0, 16'h0, 4'h0);
      bus.BlankLz = 1'b0;
      applyStimulus(4'hE, 7'h78, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hD, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_wrap4", fd_count, 4);

      // Non-BCD nibble, then a Load coincident with the wrap
      loadData(16'h00A0, 4'b0000);
      applyStimulus(4'hE, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hD, 7'h06, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hE, 7'h40, 1'b0, 1, 16'h9000, 4'b0001);
      applyStimulus(4'hD, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'h7, 7'h10, 1'b1, 0, 16'h0, 4'h0);
      checkOutput("fd_wrap6", fd_count, 6);

      // Async reset mid-scan while digit 2 is lit
      applyStimulus(4'hE, 7'h40, 1'b0, 0, 16'h0, 4'h0);
      applyStimulus(4'hD, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      applyStimulus(4'hB, 7'h40, 1'b1, 0, 16'h0, 4'h0);
      @(negedge Clk);
      Rst = 1'b1;
      bus.Refresh = 1'b0;
      #1;
      checkOutput("async_rst_an", {28'd0, bus.An}, 32'hF);
      checkOutput("async_rst_seg", {25'd0, bus.Seg}, 32'h7F);
      @(posedge Clk);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      repeat (2) @(posedge Clk);
      applyStimulus(4'hE, 7'h40, 1'b1, 0, 16'h0, 4'h0);

      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(posedge Clk);
         guard++;
      end
      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
